// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle logic/shift/add ops,
// plus iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] respuesta,
    output logic [WIDTH-1:0] outHigh,
    output logic [WIDTH-1:0] outLow,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [5:0] OP_PASS_A = 6'h00;
    localparam logic [5:0] OP_PASS_B = 6'h01;
    localparam logic [5:0] OP_AND    = 6'h02;
    localparam logic [5:0] OP_OR     = 6'h03;
    localparam logic [5:0] OP_XOR    = 6'h04;
    localparam logic [5:0] OP_NOR    = 6'h05;
    localparam logic [5:0] OP_NOT_A  = 6'h06;
    localparam logic [5:0] OP_NOT_B  = 6'h07;
    localparam logic [5:0] OP_SLL    = 6'h08;
    localparam logic [5:0] OP_SRL    = 6'h09;
    localparam logic [5:0] OP_SRA    = 6'h0A;
    localparam logic [5:0] OP_LUI    = 6'h0B;
    localparam logic [5:0] OP_ADDS   = 6'h0C;
    localparam logic [5:0] OP_ADDU   = 6'h0D;
    localparam logic [5:0] OP_SUB    = 6'h0E;
    localparam logic [5:0] OP_INC    = 6'h0F;
    localparam logic [5:0] OP_DEC    = 6'h10;
    localparam logic [5:0] OP_MULT   = 6'h11;
    localparam logic [5:0] OP_DIV    = 6'h12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [SHW-1:0]   cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_valid;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic [SHW-1:0]   shamt;
    logic             shift_big;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    logic             div0;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;
    logic             fin_v;

    assign shamt     = B[SHW-1:0];
    assign shift_big = |B[WIDTH-1:SHW];

    // Single-cycle result and carry/overflow, evaluated on the live operands
    always_comb begin
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_valid = 1'b1;
        sum      = {1'b0, A} + {1'b0, B};
        diff     = {1'b0, A} - {1'b0, B};
        inc      = {1'b0, A} + (WIDTH+1)'(1);
        dec      = {1'b0, A} - (WIDTH+1)'(1);
        case (operation)
            OP_PASS_A: sc_res = A;
            OP_PASS_B: sc_res = B;
            OP_AND:    sc_res = A & B;
            OP_OR:     sc_res = A | B;
            OP_XOR:    sc_res = A ^ B;
            OP_NOR:    sc_res = ~(A | B);
            OP_NOT_A:  sc_res = ~A;
            OP_NOT_B:  sc_res = ~B;
            OP_SLL:    sc_res = shift_big ? '0 : (A << shamt);
            OP_SRL:    sc_res = shift_big ? '0 : (A >> shamt);
            OP_SRA:    sc_res = shift_big ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> shamt);
            OP_LUI:    sc_res = {A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADDS: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADDU: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = ~diff[WIDTH];
                sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_INC: begin
                sc_res = inc[WIDTH-1:0];
                sc_c   = inc[WIDTH];
                sc_v   = ~A[WIDTH-1] & inc[WIDTH-1];
            end
            OP_DEC: begin
                sc_res = dec[WIDTH-1:0];
                sc_c   = ~dec[WIDTH];
                sc_v   = A[WIDTH-1] & ~dec[WIDTH-1];
            end
            default:   sc_valid = 1'b0;
        endcase
    end

    // One multiply (shift-add) or restoring-divide step on the shared accumulator pair
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : (WIDTH+1)'(0));
        rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_sub = WIDTH'(rem_sh - {1'b0, b_q});
        rem_ge  = (rem_sh >= {1'b0, b_q});
        if (is_div_q) begin
            acc_hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Divide-by-zero is reported explicitly rather than relying on the iteration residue
    always_comb begin
        div0   = is_div_q && (b_q == '0);
        fin_hi = div0 ? a_q : acc_hi_q;
        fin_lo = div0 ? '1  : acc_lo_q;
        fin_v  = is_div_q ? div0 : (acc_hi_q != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            respuesta <= '0;
            outHigh   <= '0;
            outLow    <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (operation == OP_MULT || operation == OP_DIV) begin
                            state_q  <= S_RUN;
                            busy     <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= (operation == OP_DIV);
                            a_q      <= A;
                            b_q      <= B;
                            acc_hi_q <= '0;
                            acc_lo_q <= (operation == OP_DIV) ? A : B;
                        end else begin
                            done      <= 1'b1;
                            respuesta <= sc_res;
                            outHigh   <= '0;
                            outLow    <= sc_res;
                            Z         <= sc_valid && (sc_res == '0);
                            N         <= sc_res[WIDTH-1];
                            C         <= sc_c;
                            V         <= sc_v;
                        end
                    end
                end
                S_RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH-1)) begin
                        state_q <= S_FIN;
                        busy    <= 1'b0;
                    end
                end
                S_FIN: begin
                    state_q   <= S_IDLE;
                    done      <= 1'b1;
                    respuesta <= fin_lo;
                    outHigh   <= fin_hi;
                    outLow    <= fin_lo;
                    Z         <= (fin_lo == '0);
                    N         <= fin_lo[WIDTH-1];
                    C         <= 1'b0;
                    V         <= fin_v;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a negedge monitor
// pops and compares on every done pulse, including the cycle at which done arrives.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  operation;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] respuesta;
    logic [31:0] outHigh;
    logic [31:0] outLow;
    logic        Z;
    logic        N;
    logic        C;
    logic        V;

    typedef struct {
        string       name;
        logic [31:0] resp;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  zncv;
        int          cyc;
    } exp_t;

    exp_t exq[$];
    int   vectors = 0;
    int   miss    = 0;
    int   cyc     = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .A(A), .B(B), .busy(busy), .done(done), .respuesta(respuesta),
        .outHigh(outHigh), .outLow(outLow), .Z(Z), .N(N), .C(C), .V(V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            vectors++;
            if (exq.size() == 0) begin
                miss++;
                $display("FAIL unexpected_done: cyc=%0d resp=%h hi=%h lo=%h", cyc, respuesta, outHigh, outLow);
            end else begin
                e = exq.pop_front();
                if (respuesta !== e.resp || outHigh !== e.hi || outLow !== e.lo ||
                    {Z, N, C, V} !== e.zncv || cyc != e.cyc) begin
                    miss++;
                    $display("FAIL %s: got resp=%h hi=%h lo=%h ZNCV=%b cyc=%0d, want resp=%h hi=%h lo=%h ZNCV=%b cyc=%0d",
                             e.name, respuesta, outHigh, outLow, {Z, N, C, V}, cyc,
                             e.resp, e.hi, e.lo, e.zncv, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic push_exp(input string nm, input logic [31:0] r, input logic [31:0] hi,
                            input logic [31:0] lo, input logic [3:0] f, input int lat);
        exp_t e;
        e.name = nm; e.resp = r; e.hi = hi; e.lo = lo; e.zncv = f; e.cyc = cyc + lat;
        exq.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op; A = a; B = b; start = 1'b1;
    endtask

    task automatic single(input string nm, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic [3:0] f);
        @(negedge clk);
        drive(op, a, b);
        push_exp(nm, r, 32'h0, r, f, 1);
    endtask

    task automatic idle_start;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain;
        int k = 0;
        while (exq.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (exq.size() != 0) begin
            vectors++;
            miss++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", exq.size());
            exq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; operation = 6'h0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_resp", respuesta, 32'h0);
        chk("reset_hilo", outHigh | outLow, 32'h0);
        chk("reset_ctl_flags", 32'({busy, done, Z, N, C, V}), 32'h0);

        // MULT aborted by reset: no done may ever appear
        @(negedge clk);
        drive(6'h11, 32'd5, 32'd7);
        idle_start();
        chk("abort_busy_running", 32'(busy), 32'h1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy_cleared", 32'({busy, done}), 32'h0);
        chk("abort_results_zero", respuesta | outHigh | outLow, 32'h0);
        repeat (40) @(negedge clk);

        // Back-to-back single-cycle ops, done expected on consecutive cycles
        single("adds_ovf",  6'h0C, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0101);
        single("sub_zero",  6'h0E, 32'h3,        32'h3,        32'h0,        4'b1010);
        single("sub_borrow",6'h0E, 32'h0,        32'h1,        32'hFFFFFFFF, 4'b0100);
        single("sub_ovf",   6'h0E, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011);
        single("addu_wrap", 6'h0D, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1010);
        single("inc_ovf",   6'h0F, 32'h7FFFFFFF, 32'h0,        32'h80000000, 4'b0101);
        single("dec_zero",  6'h10, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0100);
        single("and",       6'h02, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100);
        single("pass_b",    6'h01, 32'h0,        32'h55,       32'h55,       4'b0000);
        single("nor",       6'h05, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0100);
        single("lui",       6'h0B, 32'h1234ABCD, 32'h0,        32'hABCD0000, 4'b0100);
        single("sll_31",    6'h08, 32'h1,        32'd31,       32'h80000000, 4'b0100);
        single("sra_4",     6'h0A, 32'h80000000, 32'd4,        32'hF8000000, 4'b0100);
        single("srl_big",   6'h09, 32'h80000000, 32'd40,       32'h0,        4'b1000);
        single("sra_big",   6'h0A, 32'h80000000, 32'd40,       32'hFFFFFFFF, 4'b0100);
        single("bad_op",    6'h3F, 32'h12345678, 32'h9,        32'h0,        4'b0000);
        idle_start();
        wait_drain();

        // MULT with an ignored start five cycles in
        @(negedge clk);
        drive(6'h11, 32'hFFFFFFFF, 32'h2);
        push_exp("mult_big", 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 4'b0101, 34);
        idle_start();
        chk("mult_busy", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);
        drive(6'h00, 32'h1234, 32'h0);
        idle_start();
        wait_drain();
        repeat (3) @(negedge clk);
        chk("mult_hold", respuesta, 32'hFFFFFFFE);

        // MULT with zero low word but nonzero high word
        @(negedge clk);
        drive(6'h11, 32'h00010000, 32'h00010000);
        push_exp("mult_2p32", 32'h0, 32'h1, 32'h0, 4'b1001, 34);
        idle_start();
        wait_drain();

        // DIV with a start issued during the FIN cycle
        @(negedge clk);
        drive(6'h12, 32'd100, 32'd7);
        push_exp("div_100_7", 32'd14, 32'd2, 32'd14, 4'b0000, 34);
        idle_start();
        repeat (32) @(negedge clk);
        chk("fin_busy_low", 32'(busy), 32'h0);
        drive(6'h00, 32'h5, 32'h0);
        idle_start();
        wait_drain();
        repeat (3) @(negedge clk);

        @(negedge clk);
        drive(6'h12, 32'd100, 32'd0);
        push_exp("div_by_zero", 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 4'b0101, 34);
        idle_start();
        wait_drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Single-cycle logic, shift and arithmetic ops complete one clock after `start`.
- Adds iterative unsigned multiply and divide: shift-add and restoring, one bit per cycle, double-width result on outHigh/outLow.
- Sits between the datapath register file and the writeback stage; a start/busy/done handshake replaces free-running combinational evaluation.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from B.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  launch operation; sampled only when busy=0
- operation  in  6  opcode
- A  in  WIDTH  operand A, captured on accepted start
- B  in  WIDTH  operand B, captured on accepted start
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: results/flags updated this cycle
- respuesta  out  WIDTH  primary result
- outHigh  out  WIDTH  MULT high word / DIV remainder
- outLow  out  WIDTH  MULT low word / DIV quotient
- Z, N, C, V  out  1  zero, negative, carry, overflow flags

Behaviour:
- Reset:
  - rst_n=0 at a rising edge clears all outputs and internal state to 0; FSM returns to IDLE.
  - Reset mid-MULT/DIV aborts the op: no done pulse, results stay 0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 captures A, B, operation.
    - Single-cycle opcode: results and flags are registered at the same edge; done=1 the next cycle; stay in IDLE.
    - 0x11/0x12: go to RUN; busy=1 from the next cycle.
  - RUN: iteration counter counts 0..WIDTH-1; after the last iteration go to FIN.
  - FIN: registers outputs, done=1, busy=0; back to IDLE.
  - MULT/DIV latency: done is asserted WIDTH+1 cycles after the start edge.
- start while busy=1 is ignored; the operation is not queued.
  - start in the FIN cycle is also ignored.
  - Back-to-back single-cycle ops are accepted every cycle (done on consecutive cycles).
- Outputs hold their last value until the next done.
- Opcodes (respuesta):
  - 0x00 A; 0x01 B; 0x02 A&B; 0x03 A|B; 0x04 A^B; 0x05 ~(A|B); 0x06 ~A; 0x07 ~B.
  - 0x08 A<<B; 0x09 logical A>>B; 0x0A arithmetic A>>>B.
  - 0x0B LUI: {A[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 0x0C signed add; 0x0D unsigned add; 0x0E A-B; 0x0F A+1; 0x10 A-1.
  - 0x11 MULT unsigned: {outHigh,outLow}=A*B; respuesta=outLow.
  - 0x12 DIV unsigned: outLow=A/B, outHigh=A%B; respuesta=outLow.
  - Any other opcode: respuesta=0, outHigh=outLow=0, all flags 0, done still pulses.
- Shift rules: if B >= WIDTH (any bit above SHW-1 set), 0x08/0x09 give 0 and 0x0A gives WIDTH copies of A[WIDTH-1].
- outHigh/outLow:
  - Updated only by 0x11/0x12.
  - Every other op writes outHigh=0 and outLow=respuesta.
- Flags, updated on every done:
  - Z = (respuesta==0).
  - N = respuesta[WIDTH-1].
  - C = carry out of bit WIDTH-1 for 0x0C/0x0D/0x0F. For 0x0E/0x10, C=1 when there is no borrow (A >= subtrahend unsigned). C=0 for all other ops.
  - V = signed overflow for 0x0C/0x0E/0x0F/0x10; 0 for 0x0D and logic/shift ops.
  - MULT: V=1 iff outHigh != 0.
- Divide by zero (B=0): outLow=all ones, outHigh=A, V=1, C=0; full latency still applies.

Test Plan:
- Reset hold 3 cycles, then release → all outputs 0. Issue op 0x11 (A=5, B=7); assert rst_n=0 at cycle 10 → no done, busy=0 next cycle.
- WIDTH=32, op 0x0C, A=0x7FFFFFFF, B=1 → done next cycle, respuesta=0x80000000, N=1, V=1, C=0, Z=0.
- op 0x0E, A=3, B=3 → respuesta=0, Z=1, C=1. Then op 0x0E, A=0, B=1 → 0xFFFFFFFF, C=0, N=1.
- op 0x11, A=0xFFFFFFFF, B=2 → done at start+33: outHigh=1, outLow=0xFFFFFFFE, V=1. A start pulse at start+5 is ignored.
- op 0x12, A=100, B=7 → outLow=14, outHigh=2. Then B=0 → outLow=0xFFFFFFFF, outHigh=100, V=1.
- Shifts with A=0x80000000: B=4 → op 0x0A gives 0xF8000000. B=40 → op 0x09 gives 0, op 0x0A gives 0xFFFFFFFF. Op 0x3F → respuesta=0, done=1, flags 0.
